booth_dot_acc: RTL and testbench
================================

Name: booth_dot_acc

Overview:
- Sequencing and accumulation stage wrapped around the registered radix-4 Booth multiplier (booth4beta).
- Accepts signed operand pairs over a valid/ready handshake and drives them into the multiplier.
- Captures each registered product one cycle later and accumulates LEN products into a signed dot product.
- Presents the dot product plus a sticky overflow flag over a valid/ready output handshake.

Parameters:
- TAM, default `TAM` (8), operand width; matches the multiplier.
- LEN, default 4, products per dot product; must be ≥1.
- GUARD, default 4, extra accumulator guard bits; ACCW = 2*TAM+GUARD.
- CW, default 2, term counter width; must satisfy 2^CW ≥ LEN.

Ports:
- clk  in  1  rising-edge clock, shared with the multiplier.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_a  in  TAM  signed multiplicand.
- in_b  in  TAM  signed multiplier.
- mul_a  out  TAM  registered operand to multiplier input A.
- mul_b  out  TAM  registered operand to multiplier input B.
- mul_p  in  2*TAM  multiplier output S (registered inside the multiplier).
- out_valid  out  1  dot product valid.
- out_ready  in  1  consumer accepts the result.
- out_acc  out  ACCW  signed dot product.
- out_ovf  out  1  sticky signed overflow of the accumulator for this vector.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, mul_a=0, mul_b=0, acc=0, ovf=0, term count=0, out_valid=0, in_ready=1 (combinational from state, so high in the first cycle after reset).
- Reset mid-operation: reset wins over every other event. Any partial sum, counter and pending output are discarded; no result is emitted.
- FSM states: IDLE, MUL, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: register mul_a<=in_a and mul_b<=in_b, go to MUL.
  - Without in_valid: stay in IDLE.
- MUL: one cycle. Operands are stable at the multiplier, which samples them at the end of this cycle. Go to ADD.
- ADD: one cycle.
  - mul_p now holds the product. Sign-extend it to ACCW and add: acc<=acc+sext(mul_p).
  - ovf<=ovf | signed_overflow, where signed_overflow means both addends share a sign and the sum sign differs. Wrap-around: no saturation.
  - If count==LEN-1: count<=0, go to DONE. Otherwise count<=count+1, go to IDLE.
- DONE:
  - out_valid=1. out_acc=acc and out_ovf=ovf, held stable while out_ready=0.
  - in_ready=0; input is back-pressured.
  - On out_ready: acc<=0, ovf<=0, go to IDLE.
  - in_ready rises the following cycle, never in the same cycle as the output handshake.
- Latency: 3 cycles per term. From the accept edge of the last term, out_valid is asserted 2 edges later. With continuous in_valid, in_ready pulses high 1 cycle in 3.
- Operand hold: mul_a and mul_b keep their last value outside accept edges.
- out_acc and out_ovf are driven directly from acc and ovf in all states; they are only meaningful while out_valid=1.
- in_valid while in_ready=0 is ignored. Data is not required to be held, because only an accept edge samples it.

Decomposition:
- Shared constants package/include (const.v): TAM, the default LEN, and the state encodings IDLE=2'd0, MUL=2'd1, ADD=2'd2, DONE=2'd3.
- Natural sub-module: booth4beta, instantiated in a test wrapper booth_dot_top. The block itself contains no multiplier.
- The sign-extending overflow-checking adder may be a small sub-module acc_add_ovf.

Test Plan (TAM=8, LEN=4, GUARD=4 unless noted; DUT wired to booth4beta):
- Pairs (3,5),(-2,7),(4,-4),(-1,-1) -> out_valid with out_acc=20'hFFFF2 (-14), out_ovf=0.
- Four pairs (-128,-128) -> out_acc=20'h10000 (65536), out_ovf=0.
- GUARD=0, four pairs (-128,-128) -> after 2nd term acc wraps to 16'h8000, ovf sticks. Final out_acc=16'h0000, out_ovf=1. Next vector starts with ovf=0.
- Result ready, out_ready held 0 for 5 cycles -> out_valid, out_acc and out_ovf stable; in_ready=0; in_valid pulses ignored. out_ready=1 -> in_ready=1 the next cycle.
- in_valid held high continuously -> in_ready high exactly 1 cycle in 3. out_valid rises 2 cycles after the 4th accept edge.
- rst asserted after 2 accepted terms -> next cycle state IDLE, mul_a=mul_b=0, in_ready=1, no out_valid. A fresh vector (1,1)x4 yields out_acc=4.

Source files
------------

// File: rtl/booth_dot_acc_pkg.sv
// Shared constants for the Booth dot-product accumulator: default operand
// width, default vector length and FSM state encodings.
package booth_dot_acc_pkg;

  localparam int unsigned TAM_DEF = 8;
  localparam int unsigned LEN_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/booth_dot_acc_add.sv
// Sign-extending accumulator adder with signed-overflow detect (wraps, no saturation).
module booth_dot_acc_add #(
  parameter int unsigned PW   = 16,
  parameter int unsigned ACCW = 20
) (
  input  logic [PW-1:0]   prod,
  input  logic [ACCW-1:0] acc,
  output logic [ACCW-1:0] sum_c,
  output logic            ovf_c
);

  logic signed [ACCW-1:0] addend;

  assign addend = ACCW'($signed(prod));
  assign sum_c  = acc + addend;
  // Overflow: addends agree in sign but the sum does not.
  assign ovf_c  = (acc[ACCW-1] == addend[ACCW-1]) && (sum_c[ACCW-1] != acc[ACCW-1]);

endmodule

// File: rtl/booth_dot_acc.sv
// Sequencer around an external registered radix-4 Booth multiplier: feeds
// operand pairs, accumulates LEN products and hands out the dot product.
module booth_dot_acc
  import booth_dot_acc_pkg::*;
#(
  parameter int unsigned TAM   = TAM_DEF,
  parameter int unsigned LEN   = LEN_DEF,
  parameter int unsigned GUARD = 4,
  parameter int unsigned CW    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TAM-1:0]             in_a,
  input  logic [TAM-1:0]             in_b,
  output logic [TAM-1:0]             mul_a,
  output logic [TAM-1:0]             mul_b,
  input  logic [2*TAM-1:0]           mul_p,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*TAM+GUARD-1:0]     out_acc,
  output logic                       out_ovf
);

  localparam int unsigned PW   = 2 * TAM;
  localparam int unsigned ACCW = 2 * TAM + GUARD;

  state_t          state, state_nxt;
  logic [TAM-1:0]  mul_a_nxt, mul_b_nxt;
  logic [ACCW-1:0] acc, acc_nxt, sum_c;
  logic            ovf, ovf_nxt, ovf_c;
  logic [CW-1:0]   cnt, cnt_nxt;

  booth_dot_acc_add #(
    .PW   (PW),
    .ACCW (ACCW)
  ) u_add (
    .prod  (mul_p),
    .acc   (acc),
    .sum_c (sum_c),
    .ovf_c (ovf_c)
  );

  // State and datapath registers; reset discards any partial vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mul_a <= '0;
      mul_b <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      mul_a <= mul_a_nxt;
      mul_b <= mul_b_nxt;
      acc   <= acc_nxt;
      ovf   <= ovf_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    mul_a_nxt = mul_a;
    mul_b_nxt = mul_b;
    acc_nxt   = acc;
    ovf_nxt   = ovf;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (in_valid) begin
          mul_a_nxt = in_a;
          mul_b_nxt = in_b;
          state_nxt = MUL;
        end
      end
      MUL: state_nxt = ADD;
      ADD: begin
        acc_nxt = sum_c;
        ovf_nxt = ovf | ovf_c;
        if (cnt == CW'(LEN - 1)) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt   = cnt + CW'(1);
          state_nxt = IDLE;
        end
      end
      DONE: begin
        if (out_ready) begin
          acc_nxt   = '0;
          ovf_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake flags decode straight from the registered state.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_acc   = acc;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_booth_dot_acc.sv
// Self-checking bench: two instances (GUARD=4 and GUARD=0) fed in lockstep,
// each wired to a behavioural registered multiplier.
module tb_booth_dot_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_a, in_b;
  logic        out_ready;

  logic        in_ready, out_valid, out_ovf;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_p;
  logic [19:0] out_acc;

  logic        in_ready0, out_valid0, out_ovf0;
  logic [7:0]  mul_a0, mul_b0;
  logic [15:0] mul_p0;
  logic [15:0] out_acc0;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [19:0] acc;
    logic        ovf;
    logic [15:0] acc0;
    logic        ovf0;
  } exp_t;

  typedef struct packed {
    logic [3:0][7:0] a;
    logic [3:0][7:0] b;
    exp_t            e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];

  always #5 clk = ~clk;

  booth_dot_acc #(.TAM(8), .LEN(4), .GUARD(4), .CW(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf)
  );

  booth_dot_acc #(.TAM(8), .LEN(4), .GUARD(0), .CW(2)) u_dut_g0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .mul_a(mul_a0), .mul_b(mul_b0), .mul_p(mul_p0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_acc(out_acc0), .out_ovf(out_ovf0)
  );

  // Registered multiplier models: product visible one edge after sampling.
  logic signed [15:0] ea, eb, ea0, eb0;
  assign ea  = {{8{mul_a[7]}}, mul_a};
  assign eb  = {{8{mul_b[7]}}, mul_b};
  assign ea0 = {{8{mul_a0[7]}}, mul_a0};
  assign eb0 = {{8{mul_b0[7]}}, mul_b0};
  initial begin
    mul_p  = '0;
    mul_p0 = '0;
  end
  always @(posedge clk) begin
    mul_p  <= ea * eb;
    mul_p0 <= ea0 * eb0;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Scoreboard: every output handshake pops one expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%h expected=none", out_acc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("acc20", 32'(out_acc), 32'(e.acc));
        chk("ovf20", 32'(out_ovf), 32'(e.ovf));
        chk("valid16", 32'(out_valid0), 32'd1);
        chk("acc16", 32'(out_acc0), 32'(e.acc0));
        chk("ovf16", 32'(out_ovf0), 32'(e.ovf0));
      end
    end
  end

  function automatic vec_t mk(input int a0, b0, a1, b1, a2, b2, a3, b3,
                              input logic [19:0] acc, input logic ovf,
                              input logic [15:0] acc0, input logic ovf0);
    vec_t v;
    v.a[0] = 8'(a0); v.b[0] = 8'(b0);
    v.a[1] = 8'(a1); v.b[1] = 8'(b1);
    v.a[2] = 8'(a2); v.b[2] = 8'(b2);
    v.a[3] = 8'(a3); v.b[3] = 8'(b3);
    v.e.acc = acc; v.e.ovf = ovf; v.e.acc0 = acc0; v.e.ovf0 = ovf0;
    return v;
  endfunction

  task automatic send(input int a, input int b);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_a     = 8'(a);
    in_b     = 8'(b);
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = 8'($urandom);
    in_b     = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || !in_ready) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    vecs[0] = mk(3, 5, -2, 7, 4, -4, -1, -1, 20'hFFFF2, 1'b0, 16'hFFF2, 1'b0);
    vecs[1] = mk(-128, -128, -128, -128, -128, -128, -128, -128, 20'h10000, 1'b0, 16'h0000, 1'b1);
    vecs[2] = mk(1, 1, 1, 1, 1, 1, 1, 1, 20'h00004, 1'b0, 16'h0004, 1'b0);
    vecs[3] = mk(127, 127, 127, 127, 127, 127, 127, 127, 20'h0FC04, 1'b0, 16'hFC04, 1'b1);
    vecs[4] = mk(-128, 127, -128, 127, -128, 127, -128, 127, 20'hF0200, 1'b0, 16'h0200, 1'b1);
    vecs[5] = mk(0, 0, 100, -3, -50, 2, 7, 9, 20'hFFEAF, 1'b0, 16'hFEAF, 1'b0);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mul_a", 32'(mul_a), 32'd0);
    chk("rst_mul_b", 32'(mul_b), 32'd0);
    chk("rst_acc", 32'(out_acc), 32'd0);
    chk("rst_ovf", 32'(out_ovf), 32'd0);

    for (int v = 0; v < 6; v++) begin
      sb.push_back(vecs[v].e);
      for (int t = 0; t < 4; t++)
        send(int'($signed(vecs[v].a[t])), int'($signed(vecs[v].b[t])));
    end
    wait_idle();

    // Back-pressure: result held stable, inputs ignored.
    @(posedge clk); #2 out_ready = 1'b0;
    sb.push_back('{acc: 20'd24, ovf: 1'b0, acc0: 16'd24, ovf0: 1'b0});
    for (int t = 0; t < 4; t++) send(2, 3);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_acc", 32'(out_acc), 32'd24);
      chk("bp_ovf", 32'(out_ovf), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_mul_a", 32'(mul_a), 32'd2);
      in_valid = 1'b1;
      in_a     = 8'($urandom);
      in_b     = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1;
    @(negedge clk);
    chk("hs_in_ready", 32'(in_ready), 32'd0);
    chk("hs_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    chk("post_hs_valid", 32'(out_valid), 32'd0);
    wait_idle();

    // Continuous in_valid: one accept every third cycle.
    sb.push_back('{acc: 20'd8, ovf: 1'b0, acc0: 16'd8, ovf0: 1'b0});
    in_valid = 1'b1; in_a = 8'd1; in_b = 8'd2;
    for (int i = 0; i < 12; i++) begin
      chk("cont_in_ready", 32'(in_ready), (i % 3 == 0) ? 32'd1 : 32'd0);
      if (i == 11) chk("cont_valid_early", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    chk("cont_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    wait_idle();

    // Reset after two accepted terms discards the partial vector.
    send(5, 5);
    send(5, 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_mul_a", 32'(mul_a), 32'd0);
    chk("mid_rst_mul_b", 32'(mul_b), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_acc", 32'(out_acc), 32'd0);
    repeat (6) @(negedge clk);
    sb.push_back('{acc: 20'd4, ovf: 1'b0, acc0: 16'd4, ovf0: 1'b0});
    for (int t = 0; t < 4; t++) send(1, 1);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
